// File: rtl/trigger_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trigger_reset_sequencer
// Purpose  : Gates NUM_CHANNELS reset domains from one selectable trigger,
//            releasing each one after its own delay.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_reset_sequencer #(
  parameter int NUM_CHANNELS            = 4,
  parameter int DELAY_WIDTH             = 16,
  parameter int WATCHDOG_TIMEOUT_CYCLES = 12500000
) (
  input  logic                                clk,
  input  logic                                aresetn,
  input  logic                                cfg_enable,
  input  logic [NUM_CHANNELS-1:0]             cfg_trigger_mode,
  input  logic                                cfg_ext_trigger_sel,
  input  logic                                int_trigger,
  input  logic                                ext_trigger,
  input  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] cfg_delay,
  input  logic                                cfg_watchdog_en,
  input  logic                                watchdog,
  input  logic                                cfg_instant_reset_en,
  input  logic                                instant_reset,
  input  logic                                cfg_fault_clear,
  output logic [NUM_CHANNELS-1:0]             channel_aresetn,
  output logic                                reset_ack,
  output logic [2:0]                          state,
  output logic [1:0]                          fault_cause
);

  localparam int c_WD_W = (WATCHDOG_TIMEOUT_CYCLES > 2) ? $clog2(WATCHDOG_TIMEOUT_CYCLES) : 1;
  // Expiry is taken on the edge where the timer would reach TIMEOUT-1.
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WATCHDOG_TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_RELEASING = 3'd2,
    S_RUNNING   = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                            r_state;
  logic [1:0]                        r_ext_sync;
  logic [1:0]                        r_int_sync;
  logic [1:0]                        r_wd_sync;
  logic [1:0]                        r_inst_sync;
  logic                              r_wd_prev;
  logic                              r_trig_prev;
  logic                              r_trig_evt;
  logic [DELAY_WIDTH-1:0]            r_cnt;
  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] r_delay;
  logic [NUM_CHANNELS-1:0]           r_rel;
  logic [c_WD_W-1:0]                 r_wd_timer;

  logic                              w_trig_sel;
  logic                              w_wd_edge;
  logic                              w_inst;
  logic                              w_wd_active;
  logic                              w_wd_fault;
  logic                              w_inst_fault;
  logic                              w_fault;
  logic [NUM_CHANNELS-1:0]           w_rel_hit;
  logic [NUM_CHANNELS-1:0]           w_rel_next;
  logic                              w_all_rel;
  logic [NUM_CHANNELS-1:0]           w_cont;

  // Both trigger sources share the same chain depth so latency does not depend on the select.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_ext_sync  <= '0;
      r_int_sync  <= '0;
      r_wd_sync   <= '0;
      r_inst_sync <= '0;
      r_wd_prev   <= 1'b0;
      r_trig_prev <= 1'b0;
      r_trig_evt  <= 1'b0;
    end else begin
      r_ext_sync  <= {r_ext_sync[0], ext_trigger};
      r_int_sync  <= {r_int_sync[0], int_trigger};
      r_wd_sync   <= {r_wd_sync[0], watchdog};
      r_inst_sync <= {r_inst_sync[0], instant_reset};
      r_wd_prev   <= r_wd_sync[1];
      r_trig_prev <= w_trig_sel;
      r_trig_evt  <= w_trig_sel & ~r_trig_prev;
    end
  end

  assign w_trig_sel   = cfg_ext_trigger_sel ? r_ext_sync[1] : r_int_sync[1];
  assign w_wd_edge    = r_wd_sync[1] ^ r_wd_prev;
  assign w_inst       = r_inst_sync[1];

  assign w_wd_active  = cfg_watchdog_en && ((r_state == S_RELEASING) || (r_state == S_RUNNING));
  assign w_wd_fault   = w_wd_active && !w_wd_edge && (r_wd_timer >= c_WD_LAST);
  assign w_inst_fault = cfg_instant_reset_en && w_inst && (r_state != S_IDLE);
  assign w_fault      = w_wd_fault | w_inst_fault;

  generate
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
      assign w_rel_hit[i] = (r_cnt == r_delay[i*DELAY_WIDTH +: DELAY_WIDTH]);
    end
  endgenerate

  // Release tracking runs for every channel so a late switch to gated keeps its latched delay.
  assign w_rel_next = r_rel | w_rel_hit;
  assign w_all_rel  = &(w_rel_next | ~cfg_trigger_mode);
  assign w_cont     = ~cfg_trigger_mode & {NUM_CHANNELS{cfg_enable}};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_delay         <= '0;
      r_rel           <= '0;
      r_wd_timer      <= '0;
      channel_aresetn <= '0;
      reset_ack       <= 1'b0;
      fault_cause     <= 2'b00;
    end else begin
      if (w_wd_edge) begin
        r_wd_timer <= '0;
      end else if (w_wd_active && (r_wd_timer != c_WD_LAST)) begin
        r_wd_timer <= r_wd_timer + 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          channel_aresetn <= w_cont;
          if (cfg_enable) begin
            r_state <= S_ARMED;
          end
        end

        S_ARMED: begin
          channel_aresetn <= w_cont;
          if (w_fault) begin
            r_state     <= S_FAULT;
            reset_ack   <= 1'b1;
            fault_cause <= fault_cause | {w_inst_fault, w_wd_fault};
          end else if (!cfg_enable) begin
            r_state <= S_IDLE;
          end else if (r_trig_evt) begin
            r_delay    <= cfg_delay;
            r_cnt      <= '0;
            r_rel      <= '0;
            r_wd_timer <= '0;
            r_state    <= (cfg_trigger_mode == '0) ? S_RUNNING : S_RELEASING;
          end
        end

        S_RELEASING: begin
          if (w_fault) begin
            r_state         <= S_FAULT;
            reset_ack       <= 1'b1;
            fault_cause     <= fault_cause | {w_inst_fault, w_wd_fault};
            channel_aresetn <= w_cont;
          end else if (!cfg_enable) begin
            r_state         <= S_IDLE;
            channel_aresetn <= w_cont;
          end else begin
            r_rel           <= w_rel_next;
            channel_aresetn <= (w_rel_next & cfg_trigger_mode) | w_cont;
            if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_all_rel) begin
              r_state <= S_RUNNING;
            end
          end
        end

        S_RUNNING: begin
          if (w_fault) begin
            r_state         <= S_FAULT;
            reset_ack       <= 1'b1;
            fault_cause     <= fault_cause | {w_inst_fault, w_wd_fault};
            channel_aresetn <= w_cont;
          end else if (!cfg_enable) begin
            r_state         <= S_IDLE;
            channel_aresetn <= w_cont;
          end else begin
            channel_aresetn <= cfg_trigger_mode | w_cont;
          end
        end

        S_FAULT: begin
          channel_aresetn <= w_cont;
          // A clear is refused while the instant-reset pin is still asserted.
          if (cfg_fault_clear && !w_inst) begin
            r_state     <= S_IDLE;
            reset_ack   <= 1'b0;
            fault_cause <= 2'b00;
          end else if (w_inst_fault) begin
            fault_cause[1] <= 1'b1;
          end
        end

        default: begin
          r_state         <= S_IDLE;
          reset_ack       <= 1'b0;
          fault_cause     <= 2'b00;
          channel_aresetn <= w_cont;
        end
      endcase
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_trigger_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_reset_sequencer
// Purpose  : Directed self-checking bench for trigger_reset_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_reset_sequencer;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int WDT = 100;

  logic            clk = 1'b0;
  logic            aresetn;
  logic            cfg_enable;
  logic [N-1:0]    cfg_trigger_mode;
  logic            cfg_ext_trigger_sel;
  logic            int_trigger;
  logic            ext_trigger;
  logic [N*DW-1:0] cfg_delay;
  logic            cfg_watchdog_en;
  logic            watchdog;
  logic            cfg_instant_reset_en;
  logic            instant_reset;
  logic            cfg_fault_clear;
  logic [N-1:0]    channel_aresetn;
  logic            reset_ack;
  logic [2:0]      state;
  logic [1:0]      fault_cause;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  trigger_reset_sequencer #(
    .NUM_CHANNELS(N),
    .DELAY_WIDTH(DW),
    .WATCHDOG_TIMEOUT_CYCLES(WDT)
  ) dut (
    .clk                 (clk),
    .aresetn             (aresetn),
    .cfg_enable          (cfg_enable),
    .cfg_trigger_mode    (cfg_trigger_mode),
    .cfg_ext_trigger_sel (cfg_ext_trigger_sel),
    .int_trigger         (int_trigger),
    .ext_trigger         (ext_trigger),
    .cfg_delay           (cfg_delay),
    .cfg_watchdog_en     (cfg_watchdog_en),
    .watchdog            (watchdog),
    .cfg_instant_reset_en(cfg_instant_reset_en),
    .instant_reset       (instant_reset),
    .cfg_fault_clear     (cfg_fault_clear),
    .channel_aresetn     (channel_aresetn),
    .reset_ack           (reset_ack),
    .state               (state),
    .fault_cause         (fault_cause)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Staggered pattern: ch0 continuous, ch1/2/3 delays 0/5/10.
  function automatic logic [3:0] stag_exp(input int k);
    logic [3:0] e;
    e = 4'b0001;
    if (k >= 1)  e[1] = 1'b1;
    if (k >= 6)  e[2] = 1'b1;
    if (k >= 11) e[3] = 1'b1;
    return e;
  endfunction

  task automatic pulse_clear();
    cfg_fault_clear = 1'b1;
    tick(1);
    cfg_fault_clear = 1'b0;
  endtask

  initial begin
    aresetn              = 1'b1;
    cfg_enable           = 1'b0;
    cfg_trigger_mode     = 4'b1110;
    cfg_ext_trigger_sel  = 1'b1;
    int_trigger          = 1'b0;
    ext_trigger          = 1'b0;
    cfg_delay            = {8'd10, 8'd5, 8'd0, 8'd0};
    cfg_watchdog_en      = 1'b0;
    watchdog             = 1'b0;
    cfg_instant_reset_en = 1'b0;
    instant_reset        = 1'b0;
    cfg_fault_clear      = 1'b0;
    #2 aresetn = 1'b0;
    tick(3);
    chk("rst_ch", channel_aresetn, 0);
    chk("rst_ack", reset_ack, 0);
    chk("rst_state", state, 0);
    chk("rst_cause", fault_cause, 0);
    #3 aresetn = 1'b1;
    tick(1);
    chk("idle_state", state, 0);
    cfg_enable = 1'b1;
    tick(1);
    chk("armed_state", state, 1);
    chk("armed_ch0_follows_enable", channel_aresetn, 4'b0001);

    // Staggered release with a retrigger mid-RELEASING
    ext_trigger = 1'b1;
    tick(3);
    chk("trig_lat_n3", state, 1);
    tick(1);
    chk("trig_lat_n4", state, 2);
    chk("e0_ch", channel_aresetn, 4'b0001);
    ext_trigger = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) ext_trigger = 1'b1;
      if (k == 5) ext_trigger = 1'b0;
      tick(1);
      chk("stagger_ch", channel_aresetn, stag_exp(k));
      if (k == 10) chk("stagger_state_e10", state, 2);
      if (k == 11) chk("stagger_state_e11", state, 3);
    end

    // Retrigger while RUNNING is ignored
    ext_trigger = 1'b1;
    tick(3);
    ext_trigger = 1'b0;
    tick(8);
    chk("retrig_run_state", state, 3);
    chk("retrig_run_ch", channel_aresetn, 4'hF);

    cfg_enable = 1'b0;
    tick(1);
    chk("disable_state", state, 0);
    chk("disable_ch", channel_aresetn, 0);

    // No gated channel: straight to RUNNING
    cfg_enable       = 1'b1;
    cfg_trigger_mode = 4'b0000;
    tick(1);
    ext_trigger = 1'b1;
    tick(4);
    ext_trigger = 1'b0;
    chk("nogate_state", state, 3);
    chk("nogate_ch", channel_aresetn, 4'hF);
    cfg_enable = 1'b0;
    tick(1);

    // Maximum delay releases after 2^DW cycles
    cfg_trigger_mode = 4'b1000;
    cfg_delay        = {8'd255, 8'd0, 8'd0, 8'd0};
    cfg_enable       = 1'b1;
    tick(1);
    ext_trigger = 1'b1;
    tick(4);
    ext_trigger = 1'b0;
    chk("maxdly_releasing", state, 2);
    tick(255);
    chk("maxdly_e255_ch", channel_aresetn, 4'b0111);
    tick(1);
    chk("maxdly_e256_ch", channel_aresetn, 4'b1111);
    chk("maxdly_e256_state", state, 3);
    cfg_enable = 1'b0;
    tick(1);

    // Watchdog timeout
    cfg_trigger_mode = 4'b1110;
    cfg_delay        = {8'd10, 8'd5, 8'd0, 8'd0};
    cfg_enable       = 1'b1;
    tick(1);
    ext_trigger = 1'b1;
    tick(4);
    ext_trigger = 1'b0;
    tick(12);
    chk("wd_pre_running", state, 3);
    cfg_watchdog_en = 1'b1;
    repeat (2) begin
      watchdog = ~watchdog;
      tick(50);
    end
    watchdog = ~watchdog;
    tick(101);
    chk("wd_n101_state", state, 3);
    tick(1);
    chk("wd_n102_state", state, 4);
    chk("wd_cause", fault_cause, 2'b01);
    chk("wd_ack", reset_ack, 1);
    chk("wd_ch", channel_aresetn, 4'b0001);
    cfg_watchdog_en = 1'b0;
    cfg_enable      = 1'b0;
    tick(2);
    chk("fault_sticky_state", state, 4);
    cfg_enable = 1'b1;
    pulse_clear();
    chk("wd_clear_state", state, 0);
    chk("wd_clear_cause", fault_cause, 0);
    chk("wd_clear_ack", reset_ack, 0);

    // Instant reset from RUNNING
    tick(1);
    ext_trigger = 1'b1;
    tick(4);
    ext_trigger = 1'b0;
    tick(12);
    chk("inst_pre_running", state, 3);
    cfg_instant_reset_en = 1'b1;
    instant_reset        = 1'b1;
    tick(2);
    chk("inst_n2_state", state, 3);
    tick(1);
    chk("inst_n3_ch", channel_aresetn, 4'b0001);
    chk("inst_n3_state", state, 4);
    chk("inst_cause", fault_cause, 2'b10);
    chk("inst_ack", reset_ack, 1);
    pulse_clear();
    tick(1);
    chk("inst_clear_ignored_state", state, 4);
    chk("inst_clear_ignored_cause", fault_cause, 2'b10);
    instant_reset = 1'b0;
    tick(3);
    pulse_clear();
    chk("inst_clear_state", state, 0);
    chk("inst_clear_cause", fault_cause, 0);
    chk("inst_clear_ack", reset_ack, 0);

    // Watchdog expiry and instant reset in the same cycle
    tick(1);
    ext_trigger = 1'b1;
    tick(4);
    ext_trigger = 1'b0;
    tick(12);
    cfg_watchdog_en = 1'b1;
    watchdog        = ~watchdog;
    tick(99);
    instant_reset = 1'b1;
    tick(2);
    chk("both_n101_state", state, 3);
    tick(1);
    chk("both_state", state, 4);
    chk("both_cause", fault_cause, 2'b11);
    instant_reset   = 1'b0;
    cfg_watchdog_en = 1'b0;
    tick(3);
    pulse_clear();
    chk("both_clear_state", state, 0);

    // Async reset mid-RELEASING, then a full re-run
    tick(1);
    ext_trigger = 1'b1;
    tick(4);
    ext_trigger = 1'b0;
    tick(3);
    chk("ar_pre_ch", channel_aresetn, 4'b0011);
    #2 aresetn = 1'b0;
    #1;
    chk("ar_low_ch", channel_aresetn, 0);
    chk("ar_low_state", state, 0);
    chk("ar_low_ack", reset_ack, 0);
    chk("ar_low_cause", fault_cause, 0);
    #2 aresetn = 1'b1;
    #1;
    chk("ar_release_state", state, 0);
    tick(1);
    chk("ar_armed_state", state, 1);
    ext_trigger = 1'b1;
    tick(4);
    ext_trigger = 1'b0;
    chk("ar_rerun_releasing", state, 2);
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      chk("ar_rerun_ch", channel_aresetn, stag_exp(k));
    end
    chk("ar_rerun_running", state, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
